fc_fold_sched: RTL
==================

Name: fc_fold_sched

Overview:
- Sequencer for the folded binary FC layer: accepts one DIM_IN-bit activation vector and holds it on the XNOR-multiply/popcount datapath.
- Steps the weight/threshold bank index through all FOLD slices and thresholds the returned popcounts.
- Assembles the DIM_OUT-bit binary output vector and hands it downstream.
- Sits between the input stream and the folded comb_mult + popcount datapath and its weight ROM.

Parameters:
- DIM_IN, 110, activation vector width
- DIM_OUT, 32, output neurons; must be divisible by FOLD
- FOLD, 4, passes per vector; each pass covers S = DIM_OUT/FOLD neurons
- PIPE_LAT, 2, cycles from fold_idx/issue_vld to matching pc_in/thr_in (0 = same cycle)
- Derived: S = DIM_OUT/FOLD; FW = max(1, $clog2(FOLD)); CW = $clog2(DIM_IN+1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- in_data  in  DIM_IN  activation bits
- act_hold  out  DIM_IN  latched activations to datapath `in`
- fold_idx  out  FW  weight/threshold bank address
- issue_vld  out  1  fold_idx is a live issue this cycle
- pc_in  in  S*CW  popcounts for slice, returned PIPE_LAT cycles after issue
- thr_in  in  S*CW  thresholds for same slice, same timing as pc_in
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DIM_OUT  binary neuron outputs
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: in_ready=0 during rst, 1 on the first cycle after rst deasserts. act_hold, fold_idx, issue_vld, out_valid, out_data, busy all 0. FSM goes to IDLE; tag pipe is cleared.
- Reset mid-operation: abandons the vector. Returns arriving after reset are ignored because the tag pipe is cleared.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_data into act_hold and clear out_data; go to ISSUE with issue_cnt=0.
  - ISSUE: issue_vld=1, fold_idx=issue_cnt; issue_cnt increments each cycle. After the issue with issue_cnt=FOLD-1, go to DRAIN, or to DONE if all captures are complete.
  - DRAIN: issue_vld=0; wait for outstanding captures.
  - DONE: out_valid=1. out_data, act_hold and fold_idx are stable. On out_valid&out_ready go to IDLE with out_valid=0 on the next cycle.
- Issue/capture tracking: a PIPE_LAT-deep shift register carries the issue valid bit and index. When the tag emerges (for PIPE_LAT=0, issue_vld itself), capture slice k = tag index.
- Capture rule: out_data[k*S+j] = (pc_in[j] >= thr_in[j]), unsigned CW-bit compare, j = 0..S-1. Slice j occupies pc_in[j*CW +: CW]. Writes occur only at capture edges; no other slice changes.
- Transition to DONE happens on the edge of the last capture (k=FOLD-1). out_valid is high the next cycle.
- Latency: handshake at edge E0; first issue in cycle E0+1; last capture at edge E0+FOLD+PIPE_LAT; out_valid high from cycle E0+FOLD+PIPE_LAT+1. Defaults give out_valid 7 cycles after accept.
- Throughput: one vector per FOLD+PIPE_LAT+2 cycles minimum. in_ready is 0 outside IDLE; no input is buffered.
- act_hold must remain constant from accept until leaving DONE.
- FOLD=1: single issue with fold_idx=0, then DRAIN or DONE. Counters must not wrap; issue_cnt saturates at FOLD-1 in ISSUE.
- out_ready high in DONE's first cycle: 1-cycle out_valid pulse. out_ready low: out_valid held indefinitely, with out_data unchanged.
- in_valid while busy: ignored; the vector stays pending at the source.

Test Plan:
- Reset then idle (defaults) -> in_ready=1, busy=0, out_valid=0, out_data=0, issue_vld never asserts.
- Accept vector at E0; pc_in=thr_in+1 for slices 0,2 and pc_in=thr_in-1 for slices 1,3 -> fold_idx 0,1,2,3 on cycles E0+1..E0+4; out_valid at E0+7; out_data=32'h00FF00FF.
- Boundary compare: pc_in==thr_in in every lane of every slice -> out_data=32'hFFFFFFFF. pc_in=0 with thr_in=1 -> 32'h0. pc_in=110 with thr_in=110 -> 32'hFFFFFFFF.
- Backpressure: out_ready low for 10 cycles in DONE -> out_valid, out_data and act_hold stable; in_valid pulses ignored, in_ready=0. Raising out_ready -> one transfer, then IDLE.
- Reset asserted during ISSUE at issue_cnt=2 -> next cycle all outputs at reset values. Later pc_in returns do not alter out_data. The next vector completes correctly.
- Parameter sweep FOLD=1/PIPE_LAT=0 and FOLD=8/PIPE_LAT=3 -> out_valid exactly FOLD+PIPE_LAT+1 cycles after accept; slice mapping checked against a reference model.

Source files
------------

// File: rtl/fc_fold_sched.sv
// Fold sequencer for the binary FC layer: holds one activation vector, walks the
// weight/threshold bank through FOLD slices and thresholds returned popcounts.
module fc_fold_sched #(
  parameter  int DIM_IN   = 110,
  parameter  int DIM_OUT  = 32,
  parameter  int FOLD     = 4,
  parameter  int PIPE_LAT = 2,
  localparam int S        = DIM_OUT / FOLD,
  localparam int FW       = (FOLD > 1) ? $clog2(FOLD) : 1,
  localparam int CW       = $clog2(DIM_IN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DIM_IN-1:0]   in_data,
  output logic [DIM_IN-1:0]   act_hold,
  output logic [FW-1:0]       fold_idx,
  output logic                issue_vld,
  input  logic [S*CW-1:0]     pc_in,
  input  logic [S*CW-1:0]     thr_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DIM_OUT-1:0]  out_data,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [FW-1:0] LAST_IDX = FW'(FOLD - 1);

  state_t              state_q, state_d;
  logic [FW-1:0]       issue_cnt_q, issue_cnt_d;
  logic [DIM_IN-1:0]   act_q;
  logic [DIM_OUT-1:0]  out_data_q;
  logic                cap_vld;
  logic [FW-1:0]       cap_idx;
  logic [S-1:0]        cap_bits;
  logic                accept;
  logic                last_cap;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign issue_vld = (state_q == ISSUE);
  assign fold_idx  = issue_cnt_q;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign act_hold  = act_q;
  assign out_data  = out_data_q;
  assign last_cap  = cap_vld && (cap_idx == LAST_IDX);

  // Tag pipe mirrors the datapath latency so each popcount return knows its slice.
  if (PIPE_LAT == 0) begin : g_no_pipe
    assign cap_vld = issue_vld;
    assign cap_idx = issue_cnt_q;
  end else begin : g_pipe
    logic [PIPE_LAT-1:0] tag_vld_q;
    logic [FW-1:0]       tag_idx_q [PIPE_LAT];

    always_ff @(posedge clk) begin
      if (rst) begin
        tag_vld_q <= '0;
        for (int i = 0; i < PIPE_LAT; i++) tag_idx_q[i] <= '0;
      end else begin
        tag_vld_q[0] <= issue_vld;
        tag_idx_q[0] <= issue_cnt_q;
        for (int i = 1; i < PIPE_LAT; i++) begin
          tag_vld_q[i] <= tag_vld_q[i-1];
          tag_idx_q[i] <= tag_idx_q[i-1];
        end
      end
    end

    assign cap_vld = tag_vld_q[PIPE_LAT-1];
    assign cap_idx = tag_idx_q[PIPE_LAT-1];
  end

  for (genvar gi = 0; gi < S; gi++) begin : g_cmp
    assign cap_bits[gi] = (pc_in[gi*CW +: CW] >= thr_in[gi*CW +: CW]);
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = ISSUE;
          issue_cnt_d = '0;
        end
      end
      ISSUE: begin
        // Counter saturates on the last slice so fold_idx stays put through DONE.
        if (issue_cnt_q == LAST_IDX) state_d = last_cap ? DONE : DRAIN;
        else                         issue_cnt_d = issue_cnt_q + FW'(1);
      end
      DRAIN: begin
        if (last_cap) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          issue_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      act_q       <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      if (accept) begin
        act_q      <= in_data;
        out_data_q <= '0;
      end else if (cap_vld) begin
        out_data_q[int'(cap_idx)*S +: S] <= cap_bits;
      end
    end
  end

endmodule
